mem_port_arbiter: RTL and testbench

Shares one single-port, fixed-latency synchronous memory between the instruction-fetch requester (IF stage) and the data-access requester (MEM stage) of the 5-stage MIPS pipeline. This allows a unified instruction/data memory to replace the separate instruction and data memories. The block sequences each access through a small FSM, arbitrates between the two requesters, and returns read data with a one-cycle valid pulse. It also drives per-stage stall signals so the pipeline's hazard logic can freeze PC and the stage buffers while an access is outstanding.

---
 rtl/mem_port_arbiter.sv | 171 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port, fixed-latency synchronous memory between the
// instruction-fetch requester (IF) and the data-access requester (MEM) of a 5-stage pipeline.
// Each access is issued in IDLE, waits MEM_LAT cycles in WAIT, and is acknowledged with a
// one-cycle valid pulse in RESP. Data requests win over instruction fetches when both assert.
//
// Optional feature: define ARB_STARVE_GUARD_EN to build an IF loss counter that forces an IF
// grant after STARVE_MAX contested losses. Without it, priority is fixed to the data port.
//
// Ports:
//   CLK, RST_n                      clock, asynchronous active-low reset
//   if_req/if_addr                  instruction read request (level, held until if_valid)
//   if_gnt/if_valid/if_rdata        IF issue pulse, response pulse, registered read word
//   dm_req/dm_we/dm_addr/dm_wdata   data request (level, held until dm_valid)
//   dm_gnt/dm_valid/dm_rdata        data issue pulse, response pulse, registered read word
//   mem_en/mem_we/mem_addr/mem_wdata memory strobe and command, issue cycle only (0 otherwise)
//   mem_rdata                       memory read data, valid MEM_LAT cycles after mem_en
//   stall_if/stall_mem              per-stage stall, req & ~valid
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 7,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic              CLK,
  input  logic              RST_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_valid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if,
  output logic              stall_mem
);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic        owner_dm_q, owner_dm_d;
  logic        we_q, we_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] if_rdata_q, dm_rdata_q;

  logic grant_if, grant_dm, force_if, capture;

  // Grants are combinational in IDLE; gated by RST_n so every output is 0 while in reset.
  assign grant_dm = RST_n && (state_q == StIdle) && dm_req && !(if_req && force_if);
  assign grant_if = RST_n && (state_q == StIdle) && if_req && !grant_dm;

`ifdef ARB_STARVE_GUARD_EN
  localparam int unsigned LossW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  logic [LossW-1:0] loss_q, loss_d;

  assign force_if = (loss_q == LossW'(STARVE_MAX));

  always_comb begin
    loss_d = loss_q;
    if (grant_if) begin
      loss_d = '0;
    end else if (grant_dm && if_req) begin
      // Never exceeds STARVE_MAX: at STARVE_MAX the next contested cycle goes to IF.
      loss_d = loss_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      loss_q <= '0;
    end else begin
      loss_q <= loss_d;
    end
  end
`else
  assign force_if = 1'b0;
`endif

  // Last WAIT cycle: mem_rdata is valid now.
  assign capture = (state_q == StWait) && (cnt_q == 3'd0);

  always_comb begin
    state_d    = state_q;
    owner_dm_d = owner_dm_q;
    we_d       = we_q;
    cnt_d      = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (grant_dm || grant_if) begin
          owner_dm_d = grant_dm;
          we_d       = grant_dm && dm_we;
          cnt_d      = 3'(MEM_LAT - 1);
          state_d    = StWait;
        end
      end
      StWait: begin
        if (cnt_q == 3'd0) begin
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q    <= StIdle;
      owner_dm_q <= 1'b0;
      we_q       <= 1'b0;
      cnt_q      <= 3'd0;
    end else begin
      state_q    <= state_d;
      owner_dm_q <= owner_dm_d;
      we_q       <= we_d;
      cnt_q      <= cnt_d;
    end
  end

  // Read data registers hold until the next read completion for the same requester.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else if (capture) begin
      if (!owner_dm_q) begin
        if_rdata_q <= mem_rdata;
      end else if (!we_q) begin
        dm_rdata_q <= mem_rdata;
      end
    end
  end

  always_comb begin
    if_gnt    = grant_if;
    dm_gnt    = grant_dm;
    if_valid  = (state_q == StResp) && !owner_dm_q;
    dm_valid  = (state_q == StResp) && owner_dm_q;
    if_rdata  = if_rdata_q;
    dm_rdata  = dm_rdata_q;
    mem_en    = grant_if || grant_dm;
    mem_we    = grant_dm && dm_we;
    mem_addr  = '0;
    mem_wdata = '0;
    if (grant_dm) begin
      mem_addr  = dm_addr;
      mem_wdata = dm_we ? dm_wdata : '0;
    end else if (grant_if) begin
      mem_addr  = if_addr;
    end
    stall_if  = RST_n && if_req && !if_valid;
    stall_mem = RST_n && dm_req && !dm_valid;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int unsigned ADDR_W     = 7;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned MEM_LAT    = 2;
  localparam int unsigned STARVE_MAX = 3;

  logic              CLK = 1'b0;
  logic              RST_n;
  logic              if_req, dm_req, dm_we;
  logic [ADDR_W-1:0] if_addr, dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              if_gnt, if_valid, dm_gnt, dm_valid;
  logic [DATA_W-1:0] if_rdata, dm_rdata;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic              stall_if, stall_mem;

  always #5 CLK = ~CLK;

  mem_port_arbiter #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .MEM_LAT   (MEM_LAT),
    .STARVE_MAX(STARVE_MAX)
  ) dut (
    .CLK      (CLK),
    .RST_n    (RST_n),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_gnt   (if_gnt),
    .if_valid (if_valid),
    .if_rdata (if_rdata),
    .dm_req   (dm_req),
    .dm_we    (dm_we),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .dm_gnt   (dm_gnt),
    .dm_valid (dm_valid),
    .dm_rdata (dm_rdata),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .stall_if (stall_if),
    .stall_mem(stall_mem)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  // Memory model: preloaded contents come from init_word, writes override.
  function automatic logic [31:0] init_word(input logic [6:0] a);
    return (a == 7'd5) ? 32'hDEAD_BEEF : {16'hC0DE, 9'h0, a};
  endfunction

  bit          written [128];
  logic [31:0] wmem    [128];
  logic [31:0] pipe    [MEM_LAT];

  always @(posedge CLK) begin
    if (mem_en && mem_we) begin
      written[mem_addr] <= 1'b1;
      wmem[mem_addr]    <= mem_wdata;
    end
    if (mem_en && !mem_we) begin
      pipe[0] <= written[mem_addr] ? wmem[mem_addr] : init_word(mem_addr);
    end else begin
      pipe[0] <= 32'hBAD0_BAD0;
    end
    for (int i = 1; i < int'(MEM_LAT); i++) pipe[i] <= pipe[i-1];
  end

  assign mem_rdata = pipe[MEM_LAT-1];

  typedef struct packed {
    logic        is_dm;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] exp_dm_rdata = '0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic sample();
    @(negedge CLK);
  endtask

  // Every valid pulse must match the oldest outstanding expectation.
  always @(negedge CLK) begin
    if (RST_n === 1'b1 && (if_valid || dm_valid)) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", 128'({dm_valid, if_valid}), 128'(0));
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("valid_port", 128'({dm_valid, if_valid}), 128'(e.is_dm ? 2'b10 : 2'b01));
        chk("rdata", 128'(e.is_dm ? dm_rdata : if_rdata), 128'(e.data));
      end
    end
  end

  function automatic logic [127:0] all_outs();
    return 128'({if_gnt, if_valid, if_rdata, dm_gnt, dm_valid, dm_rdata,
                 mem_en, mem_we, mem_addr, mem_wdata, stall_if, stall_mem});
  endfunction

  // Called at the issue-cycle sample; returns at the sample of the valid cycle.
  task automatic wait_valid(input bit is_dm, input string tag);
    int lat = 0;
    logic v;
    do begin
      next_cycle();
      sample();
      lat++;
      v = is_dm ? dm_valid : if_valid;
      if (!v) begin
        chk({tag, "_no_reissue"}, 128'(mem_en), 128'(0));
        chk({tag, "_stall_wait"}, 128'(is_dm ? stall_mem : stall_if), 128'(1));
      end
    end while (!v && lat < 20);
    chk({tag, "_lat"}, 128'(lat), 128'(MEM_LAT + 1));
    chk({tag, "_stall_resp"}, 128'(is_dm ? stall_mem : stall_if), 128'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int   last_gnt;
    int   w;
    logic exp_dm;

    RST_n = 1'b0; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0;
    next_cycle();
    sample();
    chk("reset_outs", all_outs(), 128'(0));
    next_cycle();
    RST_n = 1'b1;

    // IF read of word 5
    next_cycle();
    if_req = 1'b1; if_addr = 7'd5;
    sample();
    chk("if_gnt", 128'({if_gnt, dm_gnt, mem_en, mem_we}), 128'(4'b1010));
    chk("if_mem_addr", 128'(mem_addr), 128'(5));
    chk("if_stall_issue", 128'(stall_if), 128'(1));
    sb.push_back('{is_dm: 1'b0, data: 32'hDEAD_BEEF});
    wait_valid(1'b0, "if_rd");
    next_cycle();
    if_req = 1'b0;
    sample();
    chk("if_rdata_hold", 128'({if_valid, if_rdata}), 128'({1'b0, 32'hDEAD_BEEF}));

    // dm write 0x10 then back-to-back read 0x10
    next_cycle();
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 7'h10; dm_wdata = 32'h1234_5678;
    sample();
    chk("wr_issue", 128'({dm_gnt, if_gnt, mem_en, mem_we}), 128'(4'b1011));
    chk("wr_cmd", 128'({mem_addr, mem_wdata}), 128'({7'h10, 32'h1234_5678}));
    sb.push_back('{is_dm: 1'b1, data: exp_dm_rdata});
    wait_valid(1'b1, "dm_wr");
    next_cycle();
    dm_we = 1'b0;
    sample();
    chk("rd_issue", 128'({dm_gnt, mem_en, mem_we}), 128'(3'b110));
    chk("rd_wdata_zero", 128'(mem_wdata), 128'(0));
    sb.push_back('{is_dm: 1'b1, data: 32'h1234_5678});
    exp_dm_rdata = 32'h1234_5678;
    wait_valid(1'b1, "dm_rd");
    next_cycle();
    dm_req = 1'b0;
    sample();
    chk("dm_rdata_hold", 128'({dm_valid, dm_rdata}), 128'({1'b0, 32'h1234_5678}));

    // Reset in the middle of a dm read's WAIT phase
    next_cycle();
    dm_req = 1'b1; dm_addr = 7'd5;
    sample();
    chk("rst_pre_gnt", 128'(dm_gnt), 128'(1));
    next_cycle();
    RST_n = 1'b0;
    sample();
    chk("rst_mid_outs0", all_outs(), 128'(0));
    next_cycle();
    sample();
    chk("rst_mid_outs1", all_outs(), 128'(0));
    next_cycle();
    RST_n = 1'b1; dm_req = 1'b0; if_req = 1'b1; if_addr = 7'd9;
    sample();
    chk("rst_first_gnt", 128'({if_gnt, mem_addr}), 128'({1'b1, 7'd9}));
    sb.push_back('{is_dm: 1'b0, data: init_word(7'd9)});
    exp_dm_rdata = '0;
    wait_valid(1'b0, "post_rst");
    next_cycle();
    if_req = 1'b0;
    sample();
    chk("rst_dm_rdata", 128'(dm_rdata), 128'(0));

    // Simultaneous requests: dm first, IF four cycles later
    next_cycle();
    if_req = 1'b1; if_addr = 7'd5; dm_req = 1'b1; dm_addr = 7'd7; dm_we = 1'b0;
    sample();
    chk("cont_dm_first", 128'({dm_gnt, if_gnt}), 128'(2'b10));
    last_gnt = cyc;
    sb.push_back('{is_dm: 1'b1, data: init_word(7'd7)});
    exp_dm_rdata = init_word(7'd7);
    wait_valid(1'b1, "cont_dm");
    next_cycle();
    dm_req = 1'b0;
    sample();
    chk("cont_if_next", 128'({dm_gnt, if_gnt}), 128'(2'b01));
    chk("cont_gap", 128'(cyc - last_gnt), 128'(MEM_LAT + 2));
    sb.push_back('{is_dm: 1'b0, data: 32'hDEAD_BEEF});
    wait_valid(1'b0, "cont_if");
    next_cycle();
    if_req = 1'b0;

    // Both requests held high for 50 accesses
    next_cycle();
    if_req = 1'b1; if_addr = 7'd3; dm_req = 1'b1; dm_addr = 7'd9; dm_we = 1'b0;
    last_gnt = 0;
    for (int k = 0; k < 50; k++) begin
      w = 0;
      sample();
      while (!(if_gnt || dm_gnt) && w < 10) begin
`ifndef ARB_STARVE_GUARD_EN
        chk("starve_stall_if", 128'(stall_if), 128'(1));
`endif
        next_cycle();
        sample();
        w++;
      end
`ifdef ARB_STARVE_GUARD_EN
      exp_dm = ((k % (STARVE_MAX + 1)) != STARVE_MAX);
`else
      exp_dm = 1'b1;
      chk("starve_stall_if", 128'(stall_if), 128'(1));
`endif
      chk($sformatf("grant_order_%0d", k), 128'({dm_gnt, if_gnt}), 128'({exp_dm, !exp_dm}));
      if (k > 0) chk("grant_gap", 128'(cyc - last_gnt), 128'(MEM_LAT + 2));
      last_gnt = cyc;
      sb.push_back('{is_dm: exp_dm, data: exp_dm ? init_word(7'd9) : init_word(7'd3)});
      if (exp_dm) exp_dm_rdata = init_word(7'd9);
      next_cycle();
    end
    if_req = 1'b0; dm_req = 1'b0;
    for (int i = 0; i < 6; i++) next_cycle();
    sample();
    chk("sb_drain", 128'(sb.size()), 128'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
